// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-port arbiter for one single-port synchronous RAM
// Each grant runs IDLE -> ACCESS -> DONE; ack and read data return to the granted port.
module ram_arbiter #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [A-1:0] addr0,
  input  logic [A-1:0] addr1,
  input  logic [D-1:0] wdata0,
  input  logic [D-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [D-1:0] rdata0,
  output logic [D-1:0] rdata1,
  output logic         ram_cs,
  output logic         ram_we,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  input  logic [D-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         win_q, win_d;
  logic         op_we_q, op_we_d;
  logic         ram_cs_q, ram_cs_d;
  logic         ram_we_q, ram_we_d;
  logic [A-1:0] ram_addr_q, ram_addr_d;
  logic [D-1:0] ram_din_q, ram_din_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic [D-1:0] rdata0_q, rdata0_d;
  logic [D-1:0] rdata1_q, rdata1_d;

  logic         elig0, elig1, pick1;

  // A port whose ack is showing this cycle is about to drop req; never re-grant it.
  assign elig0 = req0 & ~ack0_q;
  assign elig1 = req1 & ~ack1_q;
  assign pick1 = elig1 & (~elig0 | ~last_q);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    op_we_d    = op_we_q;
    ram_cs_d   = ram_cs_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      S_IDLE: begin
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        if (elig0 | elig1) begin
          win_d      = pick1;
          last_d     = pick1;
          op_we_d    = pick1 ? we1 : we0;
          ram_cs_d   = 1'b1;
          ram_we_d   = pick1 ? we1 : we0;
          ram_addr_d = pick1 ? addr1 : addr0;
          ram_din_d  = pick1 ? wdata1 : wdata0;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (!op_we_q) begin
          if (win_q) rdata1_d = ram_dout;
          else       rdata0_d = ram_dout;
        end
        ack0_d  = ~win_q;
        ack1_d  = win_q;
        state_d = S_IDLE;
      end
      default: begin
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      op_we_q    <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      op_we_q    <= op_we_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ram_cs   = ram_cs_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed vector bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       ram_cs, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.A(10), .D(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    logic       port;
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_din"}, 32'(ram_din), 32'd0);
    check({tag, "_ack0"}, 32'(ack0), 32'd0);
    check({tag, "_ack1"}, 32'(ack1), 32'd0);
    check({tag, "_rdata0"}, 32'(rdata0), 32'd0);
    check({tag, "_rdata1"}, 32'(rdata1), 32'd0);
  endtask

  task automatic drive(input logic port, input logic r, input logic w,
                       input logic [9:0] a, input logic [7:0] wd);
    if (port) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = wd;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = wd;
    end
  endtask

  // One access with req held through the ack cycle edge, so the mask is exercised.
  task automatic do_access(input logic port, input logic we, input logic [9:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd, input string tag);
    int  cyc;
    bit  got;
    bit  stray;
    @(posedge clk); #1;
    drive(port, 1'b1, we, addr, wdata);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_cs"}, 32'(ram_cs), 32'd1);
    check({tag, "_addr"}, 32'(ram_addr), 32'(addr));
    check({tag, "_we"}, 32'(ram_we), 32'(we));
    cyc = 1; got = 0; stray = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) check({tag, "_cs_low"}, 32'(ram_cs), 32'd0);
      if (port ? ack1 : ack0) got = 1;
      if (port ? ack0 : ack1) stray = 1;
    end
    check({tag, "_latency"}, got ? 32'(cyc) : 32'd99, 32'd3);
    check({tag, "_other_ack"}, 32'(stray), 32'd0);
    check({tag, "_rdata"}, port ? 32'(rdata1) : 32'(rdata0), 32'(exp_rd));
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 10'h000, 8'h00);
  endtask

  initial begin
    int   cyc;
    int   n;
    bit   got;
    logic p;

    vecs[0] = '{1'b0, 1'b0, 10'h010, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 10'h3FF, 8'hC3, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 10'h3FF, 8'h00, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 10'h000, 8'h11, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 10'h000, 8'h00, 8'h11};
    vecs[5] = '{1'b1, 1'b0, 10'h010, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 1'b1, 10'h010, 8'hA5, 8'h5A};
    vecs[7] = '{1'b0, 1'b0, 10'h010, 8'h00, 8'hA5};

    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    mem[10'h010] <= 8'h5A;

    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, $sformatf("v%0d", i));

    // Masked port must not be re-granted after its req falls
    do_access(1'b0, 1'b0, 10'h000, 8'h00, 8'h11, "mask");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mask_idle%0d", i), 32'({ram_cs, ack0, ack1}), 32'd0);
    end

    // Early drop: req falls during the ACCESS cycle
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'h000, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("early_cs", 32'(ram_cs), 32'd1);
    req0 = 1'b0;
    cyc = 1; got = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (ack0) got = 1;
    end
    check("early_latency", got ? 32'(cyc) : 32'd99, 32'd3);
    check("early_rdata", 32'(rdata0), 32'h11);

    // Contention straight out of reset: port 0 first, then alternate every 3 cycles
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'h010, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 10'h3FF, 8'h00);
    cyc = 0; n = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 && ack1) check("cont_both_acks", 32'd1, 32'd0);
      if (ack0 || ack1) begin
        p = ack1;
        check($sformatf("cont%0d_port", n), 32'(p), 32'(n % 2));
        check($sformatf("cont%0d_cycle", n), 32'(cyc), 32'(3 * n + 4));
        check($sformatf("cont%0d_rdata", n), p ? 32'(rdata1) : 32'(rdata0),
              p ? 32'hC3 : 32'hA5);
        n++;
        if (n == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    check("cont_ack_count", 32'(n), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("cont_quiet%0d", i), 32'({ram_cs, ack0, ack1}), 32'd0);
    end

    // Reset during the ACCESS cycle of a write of 0xFF to 0x001
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 10'h001, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_cs", 32'(ram_cs), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    drive(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_noack%0d", i), 32'({ack0, ack1}), 32'd0);
    end
    rst_n = 1'b1;
    do_access(1'b0, 1'b0, 10'h001, 8'h00, 8'h00, "rst_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
